perceptron_trainer: RTL and testbench

PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

---
 rtl/perceptron_pkg.sv | 27 ++
 rtl/perceptron_weight_upd.sv | 50 +++++
 rtl/perceptron_trainer.sv | 183 ++++++++++++++++++
 tb/tb_perceptron_trainer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron training controller.
// Holds the Q3.12 number format, the weight saturation limits,
// the error counter width and the controller FSM state encoding.
package perceptron_pkg;

    // Q3.12 signed fixed point
    localparam int unsigned Q_WIDTH = 16;
    localparam int unsigned Q_FRAC  = 12;

    // Misclassification counter width
    localparam int unsigned ERR_W = 16;

    // Saturation limits for weight results
    localparam logic [Q_WIDTH-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [Q_WIDTH-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        APPLY  = 3'd2,
        WAIT   = 3'd3,
        REPORT = 3'd4,
        UPDATE = 3'd5,
        LOAD   = 3'd6
    } state_t;

endpackage

// File: rtl/perceptron_weight_upd.sv
// Combinational single-weight update: w_new = w +/- (x >>> LR_SHIFT).
// Adds the scaled input when target=1 and subtracts it when target=0.
// The sum is formed at Q_WIDTH+1 bits and reduced to Q_WIDTH bits by
// saturation when PERCEPTRON_TRAINER_SAT_EN is defined, else by wrapping.
// Ports:
//   w      in  Q_WIDTH  current weight (signed Q3.12)
//   x      in  Q_WIDTH  sample input (signed Q3.12)
//   target in  1        expected class of the sample
//   w_new  out Q_WIDTH  updated weight
module perceptron_weight_upd
    import perceptron_pkg::*;
#(
    parameter int unsigned LR_SHIFT = 3
) (
    input  logic [Q_WIDTH-1:0] w,
    input  logic [Q_WIDTH-1:0] x,
    input  logic               target,
    output logic [Q_WIDTH-1:0] w_new
);

    localparam int unsigned SUM_W = Q_WIDTH + 1;

`ifdef PERCEPTRON_TRAINER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic signed [Q_WIDTH-1:0] delta;
    logic        [SUM_W-1:0]   w_ext;
    logic        [SUM_W-1:0]   d_ext;
    logic        [SUM_W-1:0]   sum;
    logic                      ovf;

    // Scale, accumulate at one extra bit, then reduce to the weight width
    always_comb begin
        delta = $signed(x) >>> LR_SHIFT;
        w_ext = {w[Q_WIDTH-1], w};
        d_ext = {delta[Q_WIDTH-1], delta};
        sum   = target ? (w_ext + d_ext) : (w_ext - d_ext);
        // Result leaves the 16-bit range when the two top bits disagree
        ovf   = sum[SUM_W-1] ^ sum[SUM_W-2];
        if (SAT_EN && ovf) begin
            w_new = sum[SUM_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            w_new = sum[Q_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Training/inference controller for an external two-input perceptron.
// Accepts a sample, presents it to the perceptron, waits RESULT_LATENCY
// cycles, classifies the result, counts misclassifications and, when
// training is enabled, computes and loads corrected weights.
// Optional build macro: PERCEPTRON_TRAINER_SAT_EN (saturating weight math).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_valid/s_ready               sample handshake
//   s_x1, s_x2, s_target          sample inputs (Q3.12) and expected class
//   train_en                      update weights on error when high
//   init_ld, init_w1, init_w2     initial weight load request and values
//   p_in1, p_in2                  perceptron inputs
//   p_w1_new, p_w2_new            perceptron weight load values
//   p_w1_ld, p_w2_ld              perceptron weight load strobes
//   p_w1, p_w2, p_result          perceptron weights and result
//   o_valid, o_class, o_error     result strobe, class, misclassification
//   err_cnt                       saturating misclassification count
//   busy                          high when the controller is not idle
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int unsigned RESULT_LATENCY = 2,
    parameter int unsigned LR_SHIFT       = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [Q_WIDTH-1:0] s_x1,
    input  logic [Q_WIDTH-1:0] s_x2,
    input  logic               s_target,
    input  logic               train_en,
    input  logic               init_ld,
    input  logic [Q_WIDTH-1:0] init_w1,
    input  logic [Q_WIDTH-1:0] init_w2,
    output logic [Q_WIDTH-1:0] p_in1,
    output logic [Q_WIDTH-1:0] p_in2,
    output logic [Q_WIDTH-1:0] p_w1_new,
    output logic [Q_WIDTH-1:0] p_w2_new,
    output logic               p_w1_ld,
    output logic               p_w2_ld,
    input  logic [Q_WIDTH-1:0] p_w1,
    input  logic [Q_WIDTH-1:0] p_w2,
    input  logic [Q_WIDTH-1:0] p_result,
    output logic               o_valid,
    output logic               o_class,
    output logic               o_error,
    output logic [ERR_W-1:0]   err_cnt,
    output logic               busy
);

    localparam int unsigned CNT_W = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   wait_cnt;
    logic               wait_done;
    logic               target_q;
    logic               train_q;
    logic               accept;
    logic               err_now;
    logic               ld_next;
    logic [Q_WIDTH-1:0] w1_next;
    logic [Q_WIDTH-1:0] w2_new_next;
    logic [Q_WIDTH-1:0] upd_w1;
    logic [Q_WIDTH-1:0] upd_w2;

    // Ready only in IDLE and only when no weight-init request competes
    assign s_ready   = (state == IDLE) && !init_ld;
    assign accept    = s_valid && s_ready;
    assign wait_done = (wait_cnt == CNT_W'(RESULT_LATENCY - 1));
    assign err_now   = (o_class != target_q);

    // Weight update datapath, one instance per weight
    perceptron_weight_upd #(
        .LR_SHIFT (LR_SHIFT)
    ) u_upd_w1 (
        .w      (p_w1),
        .x      (p_in1),
        .target (target_q),
        .w_new  (upd_w1)
    );

    perceptron_weight_upd #(
        .LR_SHIFT (LR_SHIFT)
    ) u_upd_w2 (
        .w      (p_w2),
        .x      (p_in2),
        .target (target_q),
        .w_new  (upd_w2)
    );

    // Next-state and next load-strobe/value decode
    always_comb begin
        state_next  = state;
        ld_next     = 1'b0;
        w1_next     = '0;
        w2_new_next = '0;

        case (state)
            IDLE: begin
                if (init_ld) begin
                    state_next = INIT;
                end else if (accept) begin
                    state_next = APPLY;
                end
            end
            INIT:   state_next = IDLE;
            APPLY:  state_next = WAIT;
            WAIT: begin
                if (wait_done) begin
                    state_next = REPORT;
                end
            end
            REPORT: state_next = (err_now && train_q) ? UPDATE : IDLE;
            UPDATE: state_next = LOAD;
            LOAD:   state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Load outputs are registered, so decode them from the next state
        if (state_next == INIT) begin
            ld_next     = 1'b1;
            w1_next     = init_w1;
            w2_new_next = init_w2;
        end else if (state_next == LOAD) begin
            ld_next     = 1'b1;
            w1_next     = upd_w1;
            w2_new_next = upd_w2;
        end
    end

    // State, sample and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            target_q <= 1'b0;
            train_q  <= 1'b0;
            p_in1    <= '0;
            p_in2    <= '0;
            p_w1_new <= '0;
            p_w2_new <= '0;
            p_w1_ld  <= 1'b0;
            p_w2_ld  <= 1'b0;
            o_valid  <= 1'b0;
            o_class  <= 1'b0;
            o_error  <= 1'b0;
            err_cnt  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            busy     <= (state_next != IDLE);
            p_w1_ld  <= ld_next;
            p_w2_ld  <= ld_next;
            p_w1_new <= w1_next;
            p_w2_new <= w2_new_next;
            o_valid  <= (state == REPORT);

            // Sample registers double as the perceptron inputs
            if (accept) begin
                p_in1    <= s_x1;
                p_in2    <= s_x2;
                target_q <= s_target;
                train_q  <= train_en;
            end

            wait_cnt <= (state == WAIT) ? (wait_cnt + CNT_W'(1)) : '0;

            if ((state == WAIT) && wait_done) begin
                o_class <= (p_result != '0);
            end

            if (state == REPORT) begin
                o_error <= err_now;
                if (err_now && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed self-checking bench for perceptron_trainer (default parameters:
// RESULT_LATENCY=2, LR_SHIFT=3). Models the perceptron weight storage and
// drives the perceptron result directly.
module tb_perceptron_trainer;

`ifdef PERCEPTRON_TRAINER_SAT_EN
    localparam logic [15:0] EXP_POS_W1 = 16'h7FFF;
    localparam logic [15:0] EXP_NEG_W1 = 16'h8000;
`else
    localparam logic [15:0] EXP_POS_W1 = 16'h8F5C;
    localparam logic [15:0] EXP_NEG_W1 = 16'h70A4;
`endif

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_x1;
    logic [15:0] s_x2;
    logic        s_target;
    logic        train_en;
    logic        init_ld;
    logic [15:0] init_w1;
    logic [15:0] init_w2;
    logic [15:0] p_in1;
    logic [15:0] p_in2;
    logic [15:0] p_w1_new;
    logic [15:0] p_w2_new;
    logic        p_w1_ld;
    logic        p_w2_ld;
    logic [15:0] p_w1;
    logic [15:0] p_w2;
    logic [15:0] p_result;
    logic        o_valid;
    logic        o_class;
    logic        o_error;
    logic [15:0] err_cnt;
    logic        busy;

    int checks;
    int failures;
    int ld_cnt;

    perceptron_trainer dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_x1     (s_x1),
        .s_x2     (s_x2),
        .s_target (s_target),
        .train_en (train_en),
        .init_ld  (init_ld),
        .init_w1  (init_w1),
        .init_w2  (init_w2),
        .p_in1    (p_in1),
        .p_in2    (p_in2),
        .p_w1_new (p_w1_new),
        .p_w2_new (p_w2_new),
        .p_w1_ld  (p_w1_ld),
        .p_w2_ld  (p_w2_ld),
        .p_w1     (p_w1),
        .p_w2     (p_w2),
        .p_result (p_result),
        .o_valid  (o_valid),
        .o_class  (o_class),
        .o_error  (o_error),
        .err_cnt  (err_cnt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Perceptron weight storage model and load-strobe counter
    initial begin
        p_w1   = '0;
        p_w2   = '0;
        ld_cnt = 0;
    end
    always @(posedge clk) begin
        if (p_w1_ld) p_w1 <= p_w1_new;
        if (p_w2_ld) p_w2 <= p_w2_new;
        if (p_w1_ld || p_w2_ld) ld_cnt = ld_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_x1     = '0;
        s_x2     = '0;
        s_target = 1'b0;
        train_en = 1'b0;
        init_ld  = 1'b0;
        init_w1  = '0;
        init_w2  = '0;
        p_result = '0;

        // Reset state
        tick();
        tick();
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_class", o_class, 0);
        chk("rst_o_error", o_error, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ld", {p_w1_ld, p_w2_ld}, 0);
        chk("rst_w_new", {p_w1_new, p_w2_new}, 0);
        chk("rst_p_in", {p_in1, p_in2}, 0);
        chk("rst_s_ready", s_ready, 1);
        rst = 1'b0;
        tick();

        // Initial weight load
        init_ld = 1'b1;
        init_w1 = 16'd8806;
        init_w2 = 16'd3072;
        #1;
        chk("init_req_s_ready", s_ready, 0);
        tick();
        init_ld = 1'b0;
        init_w1 = '0;
        init_w2 = '0;
        chk("init_ld1", p_w1_ld, 1);
        chk("init_ld2", p_w2_ld, 1);
        chk("init_w1_new", p_w1_new, 16'd8806);
        chk("init_w2_new", p_w2_new, 16'd3072);
        chk("init_s_ready", s_ready, 0);
        chk("init_busy", busy, 1);
        tick();
        chk("init_done_ld", p_w1_ld, 0);
        chk("init_done_w_new", {p_w1_new, p_w2_new}, 0);
        chk("init_done_s_ready", s_ready, 1);
        chk("init_p_w1", p_w1, 16'd8806);

        // Correctly classified sample, with latency check
        s_valid  = 1'b1;
        s_x1     = 16'd3522;
        s_x2     = 16'd5734;
        s_target = 1'b1;
        train_en = 1'b1;
        p_result = 16'd1;
        #1;
        chk("ok_s_ready", s_ready, 1);
        tick();
        s_valid  = 1'b0;
        s_x1     = 16'h1111;
        s_x2     = 16'h2222;
        s_target = 1'b0;
        train_en = 1'b0;
        chk("ok_p_in1", p_in1, 16'd3522);
        chk("ok_p_in2", p_in2, 16'd5734);
        chk("ok_busy", busy, 1);
        chk("ok_busy_s_ready", s_ready, 0);
        tick();
        tick();
        tick();
        chk("ok_valid_early", o_valid, 0);
        tick();
        chk("ok_valid", o_valid, 1);
        chk("ok_class", o_class, 1);
        chk("ok_error", o_error, 0);
        chk("ok_err_cnt", err_cnt, 0);
        chk("ok_idle_busy", busy, 0);
        chk("ok_no_load", ld_cnt, 1);
        tick();
        chk("ok_valid_pulse", o_valid, 0);
        chk("ok_class_hold", o_class, 1);
        chk("ok_p_in_hold", p_in1, 16'd3522);

        // Misclassified sample with training: weight update and load
        s_valid  = 1'b1;
        s_x1     = 16'd3522;
        s_x2     = 16'd5734;
        s_target = 1'b0;
        train_en = 1'b1;
        p_result = 16'd1;
        tick();
        s_valid = 1'b0;
        repeat (4) tick();
        chk("upd_valid", o_valid, 1);
        chk("upd_error", o_error, 1);
        chk("upd_class", o_class, 1);
        chk("upd_err_cnt", err_cnt, 1);
        chk("upd_no_ld_yet", p_w1_ld, 0);
        chk("upd_busy", busy, 1);
        tick();
        chk("load_ld1", p_w1_ld, 1);
        chk("load_ld2", p_w2_ld, 1);
        chk("load_w1_new", p_w1_new, 16'd8366);
        chk("load_w2_new", p_w2_new, 16'd2356);
        tick();
        chk("load_done_ld", {p_w1_ld, p_w2_ld}, 0);
        chk("load_done_w_new", {p_w1_new, p_w2_new}, 0);
        chk("load_done_busy", busy, 0);
        chk("load_p_w1", p_w1, 16'd8366);
        chk("load_p_w2", p_w2, 16'd2356);

        // Inference-only error; init_ld while busy is ignored
        s_valid  = 1'b1;
        s_target = 1'b0;
        train_en = 1'b0;
        tick();
        s_valid = 1'b0;
        tick();
        init_ld = 1'b1;
        init_w1 = 16'd1234;
        init_w2 = 16'd4321;
        #1;
        chk("inf_init_s_ready", s_ready, 0);
        tick();
        tick();
        init_ld = 1'b0;
        tick();
        chk("inf_valid", o_valid, 1);
        chk("inf_error", o_error, 1);
        chk("inf_err_cnt", err_cnt, 2);
        chk("inf_busy", busy, 0);
        tick();
        chk("inf_no_load", ld_cnt, 2);
        chk("inf_p_w1", p_w1, 16'd8366);

        // Positive overflow of the weight sum; negative input shift
        init_ld = 1'b1;
        init_w1 = 16'd32700;
        init_w2 = 16'd0;
        tick();
        init_ld = 1'b0;
        tick();
        s_valid  = 1'b1;
        s_x1     = 16'd32000;
        s_x2     = 16'hFFFD;
        s_target = 1'b1;
        train_en = 1'b1;
        p_result = 16'd0;
        tick();
        s_valid = 1'b0;
        repeat (4) tick();
        chk("pos_class", o_class, 0);
        chk("pos_err_cnt", err_cnt, 3);
        tick();
        chk("pos_w1_new", p_w1_new, EXP_POS_W1);
        chk("pos_w2_new", p_w2_new, 16'hFFFF);
        tick();

        // Negative overflow of the weight sum
        init_ld = 1'b1;
        init_w1 = 16'h8044;
        init_w2 = 16'd100;
        tick();
        init_ld = 1'b0;
        tick();
        s_valid  = 1'b1;
        s_x1     = 16'd32000;
        s_x2     = 16'd16;
        s_target = 1'b0;
        train_en = 1'b1;
        p_result = 16'h8000;
        tick();
        s_valid = 1'b0;
        repeat (4) tick();
        chk("neg_err_cnt", err_cnt, 4);
        tick();
        chk("neg_w1_new", p_w1_new, EXP_NEG_W1);
        chk("neg_w2_new", p_w2_new, 16'd98);
        tick();
        chk("neg_load_cnt", ld_cnt, 6);

        // Reset while in UPDATE aborts the pending load
        s_valid  = 1'b1;
        s_target = 1'b0;
        train_en = 1'b1;
        p_result = 16'd5;
        tick();
        s_valid = 1'b0;
        repeat (4) tick();
        chk("abort_valid", o_valid, 1);
        chk("abort_err_cnt", err_cnt, 5);
        chk("abort_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("abort_ld", {p_w1_ld, p_w2_ld}, 0);
        chk("abort_w_new", {p_w1_new, p_w2_new}, 0);
        chk("abort_busy_clr", busy, 0);
        chk("abort_err_cnt_clr", err_cnt, 0);
        chk("abort_s_ready", s_ready, 1);
        chk("abort_valid_clr", o_valid, 0);
        rst = 1'b0;
        tick();
        chk("abort_ld_after", p_w1_ld, 0);
        tick();
        chk("abort_load_cnt", ld_cnt, 6);
        chk("abort_p_w1", p_w1, 32'(EXP_NEG_W1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
